// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
//   NREQ_DEF : default number of writeback requesters (ALU, load, mul/div)
//   DW_DEF   : register data width
//   AW_DEF   : register address width
//   NREG_DEF : number of architectural registers (2**AW_DEF)
//   REG_ZERO : hard-wired zero register, never written and never busy
package regfile_wb_arbiter_pkg;
    localparam int NREQ_DEF = 3;
    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int NREG_DEF = 1 << AW_DEF;
    localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between NREQ requesters and the arbiter.
//   req_valid : requester i has a write pending (held until transfer)
//   req_ready : requester i accepted this cycle (one-hot or zero)
//   req_addr  : destination register, slice i = [i*AW +: AW]
//   req_data  : write data, slice i = [i*DW +: DW]
// master = requester side, slave = arbiter side.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating start pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req_i      : request vector
//   grant_o    : one-hot grant, zero when no request
// The search starts at the pointer and wraps N-1 -> 0; after a grant to i
// the pointer moves to (i+1) mod N, otherwise it holds.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    int            idx;

    // Walk from the farthest candidate back to the pointer so the last
    // hit written is the one nearest the pointer.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                ptr_d        = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NREQ writeback sources.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wb          : requester bus (valid/ready/addr/data), slave side
//   rsv_valid_i : issue stage reserves a destination register
//   rsv_addr_i  : register being reserved
//   rf_we_o     : registered write enable to register file / decoder
//   rf_waddr_o  : registered write address
//   rf_wdata_o  : registered write data
//   busy_o      : per-register outstanding-write scoreboard
// One request is accepted whenever any valid is high; the accepted write
// appears on the rf_* outputs one cycle later.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 rsv_valid_i,
    input  logic [AW-1:0]        rsv_addr_i,
    output logic                 rf_we_o,
    output logic [AW-1:0]        rf_waddr_o,
    output logic [DW-1:0]        rf_wdata_o,
    output logic [NREG-1:0]      busy_o
);
    logic [NREQ-1:0] grant;
    logic            accept;
    logic            wr_en;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            rf_we_q,    rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0] busy_q,     busy_d;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (wb.req_valid),
        .grant_o (grant)
    );

    assign wb.req_ready = grant;
    assign accept       = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = wb.req_addr[i*AW +: AW];
                sel_data = wb.req_data[i*DW +: DW];
            end
        end
    end

    // Writes to the zero register are consumed but never reach the file;
    // the address/data outputs keep the last real write.
    assign wr_en = accept && (sel_addr != AW'(REG_ZERO));

    always_comb begin
        rf_we_d    = wr_en;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wr_en) begin
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
        end

        // Reservation is applied after the clear: a new producer for the
        // same register keeps it busy.
        busy_d = busy_q;
        if (accept) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (rsv_valid_i) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign busy_o     = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            rsv_valid = 1'b0;
    logic [AW-1:0]   rsv_addr = '0;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic [NREG-1:0] busy;

    regfile_wb_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) wbif ();

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb          (wbif.slave),
        .rsv_valid_i (rsv_valid),
        .rsv_addr_i  (rsv_addr),
        .rf_we_o     (rf_we),
        .rf_waddr_o  (rf_waddr),
        .rf_wdata_o  (rf_wdata),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: abstract view of the port
    int          m_ptr;
    bit          m_busy [NREG];
    bit          m_we;
    int          m_waddr;
    logic [DW-1:0] m_wdata;

    // Requester side: pending write per source
    bit          pend   [NREQ];
    int          r_addr [NREQ];
    logic [DW-1:0] r_data [NREQ];

    logic [NREQ-1:0] last_rdy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] busy_vec();
        logic [NREG-1:0] v;
        v = '0;
        for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive(input bit rv, input int ra);
        logic [NREQ-1:0]    v;
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        for (int i = 0; i < NREQ; i++) begin
            v[i]           = pend[i];
            a[i*AW +: AW]  = AW'(r_addr[i]);
            d[i*DW +: DW]  = r_data[i];
        end
        wbif.req_valid = v;
        wbif.req_addr  = a;
        wbif.req_data  = d;
        rsv_valid      = rv;
        rsv_addr       = AW'(ra);
    endtask

    task automatic cycle(input string tag, input bit rv, input int ra);
        int g;
        logic [NREQ-1:0] exp_rdy;
        drive(rv, ra);
        @(negedge clk);
        g = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        last_rdy = wbif.req_ready;
        check({tag, "_ready"}, 64'(last_rdy), 64'(exp_rdy));
        @(posedge clk);
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            m_we  = (r_addr[g] != 0);
            if (m_we) begin
                m_waddr = r_addr[g];
                m_wdata = r_data[g];
            end
            m_busy[r_addr[g]] = 1'b0;
            pend[g] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (rv && ra != 0) m_busy[ra] = 1'b1;
        #1;
        check({tag, "_we"},    64'(rf_we),    64'(m_we));
        check({tag, "_waddr"}, 64'(rf_waddr), 64'(m_waddr));
        check({tag, "_wdata"}, 64'(rf_wdata), 64'(m_wdata));
        check({tag, "_busy"},  64'(busy),     64'(busy_vec()));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_we",    64'(rf_we),    64'(0));
        check("rst_waddr", 64'(rf_waddr), 64'(0));
        check("rst_wdata", 64'(rf_wdata), 64'(0));
        check("rst_busy",  64'(busy),     64'(0));
        m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = '0;
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; r_addr[i] = 0; r_data[i] = '0;
        end
        drive(1'b0, 0);
        #1;
        check("rst_ready", 64'(wbif.req_ready), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; r_addr[i] = 0; r_data[i] = '0;
        end
        drive(1'b0, 0);
        @(posedge clk);
        #1;
        do_reset();

        // Single write from requester 0
        pend[0] = 1'b1; r_addr[0] = 5; r_data[0] = 32'hDEADBEEF;
        cycle("t2a", 1'b0, 0);
        check("t2_rdy0", 64'(last_rdy), 64'(3'b001));
        check("t2_we1",  64'(rf_we),    64'(1));
        check("t2_addr", 64'(rf_waddr), 64'(5));
        check("t2_data", 64'(rf_wdata), 64'(32'hDEADBEEF));
        cycle("t2b", 1'b0, 0);
        check("t2_we0",  64'(rf_we),    64'(0));

        // Reset while a write sits in the output stage
        pend[1] = 1'b1; r_addr[1] = 3; r_data[1] = 32'h1234_5678;
        cycle("t1a", 1'b1, 12);
        check("t1_we_pre", 64'(rf_we), 64'(1));
        do_reset();

        // All three valid continuously from pointer 0
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    pend[i] = 1'b1; r_addr[i] = 1 + i + 3 * k; r_data[i] = $urandom;
                end
            end
            cycle("t3", 1'b0, 0);
            check("t3_order", 64'(last_rdy), 64'(1 << (k % 3)));
            check("t3_we",    64'(rf_we),    64'(1));
        end
        do_reset();

        // Write to register 0 is consumed without a file write
        pend[1] = 1'b1; r_addr[1] = 0; r_data[1] = 32'h1;
        cycle("t4a", 1'b1, 0);
        check("t4_rdy1", 64'(last_rdy), 64'(3'b010));
        check("t4_we",   64'(rf_we),    64'(0));
        check("t4_b0",   64'(busy[0]),  64'(0));
        cycle("t4b", 1'b0, 0);

        // Scoreboard set / clear timing and set-wins collision
        cycle("t5a", 1'b1, 7);
        check("t5_b7_t1", 64'(busy[7]), 64'(1));
        cycle("t5b", 1'b0, 0);
        cycle("t5c", 1'b0, 0);
        check("t5_b7_t3", 64'(busy[7]), 64'(1));
        pend[0] = 1'b1; r_addr[0] = 7; r_data[0] = 32'hA5A5_0007;
        cycle("t5d", 1'b0, 0);
        check("t5_b7_t4", 64'(busy[7]), 64'(0));
        pend[1] = 1'b1; r_addr[1] = 9; r_data[1] = 32'h0000_0009;
        cycle("t5e", 1'b1, 9);
        check("t5_b9", 64'(busy[9]), 64'(1));
        do_reset();

        // Only requester 2 valid: pointer wraps back to 0
        pend[2] = 1'b1; r_addr[2] = 4; r_data[2] = 32'hCAFE_0002;
        cycle("t6a", 1'b0, 0);
        check("t6_rdy2", 64'(last_rdy), 64'(3'b100));
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1; r_addr[i] = 10 + i; r_data[i] = $urandom;
        end
        cycle("t6b", 1'b0, 0);
        check("t6_wrap", 64'(last_rdy), 64'(3'b001));

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i]   = 1'b1;
                    r_addr[i] = $urandom_range(0, NREG - 1);
                    r_data[i] = $urandom;
                end
            end
            cycle("rnd", ($urandom_range(0, 3) == 0), $urandom_range(0, NREG - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
